// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the masters/targets and mem_bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_bus_arbiter_if #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int DATA_WIDTH     = 8
);
    logic                              dbg_break_in;
    logic [NUM_MASTERS-1:0]            m_req_in;
    logic [NUM_MASTERS-1:0]            m_lock_in;
    logic [NUM_MASTERS-1:0]            m_wr_in;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_in;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dout_in;
    logic [NUM_MASTERS-1:0]            m_gnt_out;
    logic [NUM_MASTERS-1:0]            m_rdy_out;
    logic [NUM_MASTERS-1:0]            m_rvalid_out;
    logic [DATA_WIDTH-1:0]             m_din_out;
    logic                              ram_en_out;
    logic                              ram_r_nw_out;
    logic [RAM_ADDR_WIDTH-1:0]         ram_a_out;
    logic [DATA_WIDTH-1:0]             ram_d_out;
    logic [DATA_WIDTH-1:0]             ram_d_in;
    logic                              io_en_out;
    logic                              io_wr_out;
    logic [2:0]                        io_sel_out;
    logic [DATA_WIDTH-1:0]             io_d_out;
    logic [DATA_WIDTH-1:0]             io_d_in;

    modport slave (
        input  dbg_break_in, m_req_in, m_lock_in, m_wr_in, m_addr_in, m_dout_in,
        input  ram_d_in, io_d_in,
        output m_gnt_out, m_rdy_out, m_rvalid_out, m_din_out,
        output ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out,
        output io_en_out, io_wr_out, io_sel_out, io_d_out
    );

    modport master (
        output dbg_break_in, m_req_in, m_lock_in, m_wr_in, m_addr_in, m_dout_in,
        output ram_d_in, io_d_in,
        input  m_gnt_out, m_rdy_out, m_rvalid_out, m_din_out,
        input  ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out,
        input  io_en_out, io_wr_out, io_sel_out, io_d_out
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin byte-bus arbiter with lock, debug-break priority, RAM/IO decode,
// tagged 1-cycle read return and an integrated reset synchroniser.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int RAM_ADDR_WIDTH  = 17,
    parameter int DATA_WIDTH      = 8,
    parameter int RST_SYNC_STAGES = 2
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    output logic               rst_sync_out,
    mem_bus_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] DBG_PAUSE_MASK = {{(NUM_MASTERS-1){1'b1}}, 1'b0};

    logic [RST_SYNC_STAGES-1:0] rst_sync_r;
    logic                       srst_s;
    logic [NUM_MASTERS-1:0]     gnt_r;
    logic [NUM_MASTERS-1:0]     gnt_nxt_s;
    logic [PTR_W-1:0]           ptr_r;
    logic [PTR_W-1:0]           ptr_nxt_s;
    logic [NUM_MASTERS-1:0]     rvalid_r;
    logic                       rd_io_r;
    logic                       hold_s;
    logic                       found_s;
    int                         rr_idx_s;
    logic [RAM_ADDR_WIDTH:0]    addr_s;
    logic [DATA_WIDTH-1:0]      dout_s;
    logic                       wr_s;
    logic                       any_gnt_s;
    logic                       is_io_s;

    // Reset synchroniser: asserts immediately, releases after RST_SYNC_STAGES edges.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_r <= '1;
        end else begin
            rst_sync_r <= {rst_sync_r[RST_SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign srst_s       = rst_sync_r[RST_SYNC_STAGES-1];
    assign rst_sync_out = srst_s;

    // Next-grant selection: lock hold, debug-break override, then round-robin.
    always_comb begin
        gnt_nxt_s = '0;
        ptr_nxt_s = ptr_r;
        found_s   = 1'b0;
        rr_idx_s  = 0;
        // A locked owner other than master 0 is preempted by debug break.
        hold_s    = (|(gnt_r & bus.m_req_in & bus.m_lock_in)) &
                    ~(bus.dbg_break_in & ~gnt_r[0]);
        if (hold_s) begin
            gnt_nxt_s = gnt_r;
        end else if (bus.dbg_break_in) begin
            if (bus.m_req_in[0]) begin
                gnt_nxt_s[0] = 1'b1;
                ptr_nxt_s    = '0;
            end else begin
                gnt_nxt_s = '0;
            end
        end else begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                rr_idx_s = int'(ptr_r) + k;
                rr_idx_s = (rr_idx_s >= NUM_MASTERS) ? (rr_idx_s - NUM_MASTERS) : rr_idx_s;
                if (!found_s && bus.m_req_in[rr_idx_s]) begin
                    found_s             = 1'b1;
                    gnt_nxt_s[rr_idx_s] = 1'b1;
                    ptr_nxt_s           = PTR_W'(rr_idx_s);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Grant, pointer and read-return tag registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            gnt_r    <= '0;
            ptr_r    <= PTR_LAST;
            rvalid_r <= '0;
            rd_io_r  <= 1'b0;
        end else if (srst_s) begin
            gnt_r    <= '0;
            ptr_r    <= PTR_LAST;
            rvalid_r <= '0;
            rd_io_r  <= 1'b0;
        end else begin
            gnt_r    <= gnt_nxt_s;
            ptr_r    <= ptr_nxt_s;
            rvalid_r <= gnt_r & ~bus.m_wr_in;
            rd_io_r  <= is_io_s;
        end
    end

    // Granted master's access fields; zero when nobody owns the bus.
    always_comb begin
        addr_s = '0;
        dout_s = '0;
        wr_s   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            addr_s = gnt_r[i] ? bus.m_addr_in[i*ADDR_WIDTH +: RAM_ADDR_WIDTH+1] : addr_s;
            dout_s = gnt_r[i] ? bus.m_dout_in[i*DATA_WIDTH +: DATA_WIDTH]       : dout_s;
            wr_s   = gnt_r[i] ? bus.m_wr_in[i]                                   : wr_s;
        end
    end

    assign any_gnt_s = |gnt_r;
    assign is_io_s   = any_gnt_s & (addr_s[RAM_ADDR_WIDTH -: 2] == 2'b11);

    // Target-side drive and master-side return/ready.
    always_comb begin
        bus.ram_en_out   = any_gnt_s & ~is_io_s;
        bus.ram_r_nw_out = ~(any_gnt_s & ~is_io_s & wr_s);
        bus.ram_a_out    = addr_s[RAM_ADDR_WIDTH-1:0];
        bus.ram_d_out    = dout_s;
        bus.io_en_out    = is_io_s;
        bus.io_wr_out    = is_io_s & wr_s;
        bus.io_sel_out   = addr_s[2:0];
        bus.io_d_out     = dout_s;
        bus.m_gnt_out    = gnt_r;
        bus.m_rvalid_out = rvalid_r;
        // Return mux follows the decode captured when the read was issued.
        if (|rvalid_r) begin
            bus.m_din_out = rd_io_r ? bus.io_d_in : bus.ram_d_in;
        end else begin
            bus.m_din_out = '0;
        end
        bus.m_rdy_out = {NUM_MASTERS{~srst_s}} & ~({NUM_MASTERS{bus.dbg_break_in}} & DBG_PAUSE_MASK);
    end
endmodule
